// File: rtl/ascon_pkg.sv
// ============================================================================
// Module      : ascon_pkg
// Description : Shared constants and types for the Ascon block feeder:
//               mode encodings, rate defaults, FSM state type and a rate
//               lookup helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ascon_pkg;

    // Mode encodings carried on sel_type
    localparam logic [1:0] AEAD128 = 2'b00;
    localparam logic [1:0] HASH256 = 2'b01;
    localparam logic [1:0] XOF128  = 2'b10;
    localparam logic [1:0] CXOF128 = 2'b11;

    // Default block rates in bytes
    localparam int unsigned AEAD_RATE_BYTES = 16;
    localparam int unsigned HASH_RATE_BYTES = 8;

    // Feeder FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_FILL  = 2'd1;
    localparam state_t ST_ISSUE = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    // Block size in bytes for a given mode
    function automatic logic [31:0] rate_for(input logic [1:0]  sel,
                                             input int unsigned aead_rate,
                                             input int unsigned hash_rate);
        logic [31:0] r;
        case (sel)
            AEAD128:                   r = 32'(aead_rate);
            HASH256, XOF128, CXOF128:  r = 32'(hash_rate);
            default:                   r = 32'(hash_rate);
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ascon_block_feeder_if.sv
// ============================================================================
// Module      : ascon_block_feeder_if
// Description : 32-bit word stream into the block feeder (valid/ready).
//               master = upstream word source, slave = feeder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ascon_block_feeder_if;
    logic        in_valid;
    logic [31:0] in_word;
    logic        in_ready;

    modport master (output in_valid, output in_word, input  in_ready);
    modport slave  (input  in_valid, input  in_word, output in_ready);
endinterface

`default_nettype wire

// File: rtl/ascon_block_feeder.sv
// ============================================================================
// Module      : ascon_block_feeder
// Description : Packs a byte stream arriving as 32-bit words into rate-sized,
//               right-aligned blocks for the Ascon absorb stage and strobes
//               process_en once per block. Always issues at least one block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ascon_block_feeder
    import ascon_pkg::*;
#(
    parameter int unsigned AEAD_RATE = AEAD_RATE_BYTES,
    parameter int unsigned HASH_RATE = HASH_RATE_BYTES
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         start,
    input  wire logic [1:0]   sel_type_i,
    input  wire logic [31:0]  length_i,
    ascon_block_feeder_if.slave in_if,
    output logic [127:0]      data,
    output logic [31:0]       data_position,
    output logic [31:0]       data_length,
    output logic [1:0]        sel_type,
    output logic              process_en,
    output logic              busy,
    output logic              done
);

    state_t        state_q, state_d;
    logic [31:0]   pos_q,   pos_d;
    logic [31:0]   len_q,   len_d;
    logic [1:0]    sel_q,   sel_d;
    logic [127:0]  data_q,  data_d;
    logic [31:0]   fill_q,  fill_d;
    logic          pe_q,    pe_d;
    logic          busy_q,  busy_d;
    logic          done_q,  done_d;

    logic [31:0]   rate_w;
    logic [31:0]   remain_w;
    logic [31:0]   tgt_w;
    logic [31:0]   gap_w;
    logic [31:0]   k_w;
    logic          ready_w;
    logic [127:0]  packed_w;

    // Block target and per-word byte count; pos never exceeds len so remain is safe
    always_comb begin
        rate_w   = rate_for(sel_q, AEAD_RATE, HASH_RATE);
        remain_w = len_q - pos_q;
        tgt_w    = (remain_w < rate_w) ? remain_w : rate_w;
        gap_w    = tgt_w - fill_q;
        k_w      = (gap_w > 32'd4) ? 32'd4 : gap_w;
        ready_w  = (state_q == ST_FILL) && (fill_q < tgt_w);
    end

    assign in_if.in_ready = ready_w;

    // Shift-packer: append the top k bytes of the word, dropping the rest
    always_comb begin
        case (k_w)
            32'd1:   packed_w = {data_q[119:0], in_if.in_word[31:24]};
            32'd2:   packed_w = {data_q[111:0], in_if.in_word[31:16]};
            32'd3:   packed_w = {data_q[103:0], in_if.in_word[31:8]};
            default: packed_w = {data_q[95:0],  in_if.in_word};
        endcase
    end

    // Next-state logic for the IDLE/FILL/ISSUE/DONE sequencer
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        len_d   = len_q;
        sel_d   = sel_q;
        data_d  = data_q;
        fill_d  = fill_q;
        pe_d    = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d   = length_i;
                    sel_d   = sel_type_i;
                    pos_d   = 32'd0;
                    data_d  = 128'd0;
                    fill_d  = 32'd0;
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (ready_w) begin
                    if (in_if.in_valid) begin
                        data_d = packed_w;
                        fill_d = fill_q + k_w;
                        if ((fill_q + k_w) == tgt_w) begin
                            state_d = ST_ISSUE;
                            pe_d    = 1'b1;
                        end
                    end
                end else begin
                    // Block already complete (covers the empty-message case)
                    state_d = ST_ISSUE;
                    pe_d    = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (remain_w <= rate_w) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    pos_d   = pos_q + rate_w;
                    data_d  = 128'd0;
                    fill_d  = 32'd0;
                    state_d = ST_FILL;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset aborts any job in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pos_q   <= 32'd0;
            len_q   <= 32'd0;
            sel_q   <= 2'd0;
            data_q  <= 128'd0;
            fill_q  <= 32'd0;
            pe_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            len_q   <= len_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            fill_q  <= fill_d;
            pe_q    <= pe_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign data          = data_q;
    assign data_position = pos_q;
    assign data_length   = len_q;
    assign sel_type      = sel_q;
    assign process_en    = pe_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

`default_nettype wire

// File: tb/tb_ascon_block_feeder.sv
// ============================================================================
// Module      : tb_ascon_block_feeder
// Description : Self-checking bench for ascon_block_feeder. A byte-level
//               reference model splits each message into rate-sized blocks
//               and is compared with the strobed blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ascon_block_feeder;
    import ascon_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   sel_type_i = 2'd0;
    logic [31:0]  length_i = 32'd0;
    logic [127:0] data;
    logic [31:0]  data_position;
    logic [31:0]  data_length;
    logic [1:0]   sel_type;
    logic         process_en;
    logic         busy;
    logic         done;

    ascon_block_feeder_if bus ();

    ascon_block_feeder dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .sel_type_i    (sel_type_i),
        .length_i      (length_i),
        .in_if         (bus.slave),
        .data          (data),
        .data_position (data_position),
        .data_length   (data_length),
        .sel_type      (sel_type),
        .process_en    (process_en),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // stimulus / capture state
    logic [31:0]  words[$];
    logic [7:0]   msg[$];
    logic [127:0] exp_data[$];
    logic [31:0]  exp_pos[$];
    logic [127:0] cap_data[$];
    logic [31:0]  cap_pos[$];
    logic [31:0]  cap_len[$];
    logic [1:0]   cap_sel[$];
    int           cap_cyc[$];
    int           acc_cyc[$];
    int           vmode = 0;
    bit           drv_en = 0;
    int           acc_cnt = 0;
    int           done_cnt = 0;
    int           done_cyc = 0;
    int           start_cyc = 0;
    int           first_rdy_cyc = 0;
    bit           seen_rdy = 0;
    bit           timeout = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // monitor: sample on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.in_valid && bus.in_ready) begin
                acc_cnt <= acc_cnt + 1;
                acc_cyc.push_back(cyc);
            end
            if (bus.in_ready && !seen_rdy) begin
                seen_rdy      <= 1'b1;
                first_rdy_cyc <= cyc;
            end
            if (process_en) begin
                cap_data.push_back(data);
                cap_pos.push_back(data_position);
                cap_len.push_back(data_length);
                cap_sel.push_back(sel_type);
                cap_cyc.push_back(cyc);
            end
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
            if (start && !busy) start_cyc <= cyc;
        end
    end

    // word driver: updates just after the rising edge
    always @(posedge clk) begin
        #1;
        if (drv_en && acc_cnt < words.size()) begin
            case (vmode)
                0:       bus.in_valid = 1'b1;
                1:       bus.in_valid = cyc[0];
                default: bus.in_valid = 1'($urandom_range(0, 1));
            endcase
            bus.in_word = words[acc_cnt];
        end else begin
            bus.in_valid = 1'b0;
            bus.in_word  = $urandom;
        end
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_word  = 32'd0;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // random message of L bytes; junk bytes fill the tail of the last word
    task automatic prep_random(input int L);
        logic [31:0] w;
        msg.delete();
        words.delete();
        for (int i = 0; i < L; i++) msg.push_back(8'($urandom));
        for (int j = 0; j < (L + 3) / 4; j++) begin
            w = 32'd0;
            for (int b = 0; b < 4; b++)
                w = (w << 8) | ((4*j + b < L) ? 32'(msg[4*j + b]) : 32'($urandom_range(0, 255)));
            words.push_back(w);
        end
    endtask

    // derive the message bytes from explicitly given words
    task automatic prep_from_words(input int L);
        logic [31:0] w;
        msg.delete();
        for (int i = 0; i < L; i++) begin
            w = words[i / 4];
            msg.push_back(w[8*(3 - i % 4) +: 8]);
        end
    endtask

    // reference: split the message into rate-sized right-aligned blocks
    task automatic build_expect(input logic [1:0] sel, input int L);
        int rate, nblk, st, blen;
        logic [127:0] v;
        exp_data.delete();
        exp_pos.delete();
        rate = (sel == 2'b00) ? 16 : 8;
        nblk = (L == 0) ? 1 : (L + rate - 1) / rate;
        for (int b = 0; b < nblk; b++) begin
            st   = b * rate;
            blen = (L - st < rate) ? L - st : rate;
            v    = 128'd0;
            for (int i = 0; i < blen; i++) v = (v << 8) | 128'(msg[st + i]);
            exp_data.push_back(v);
            exp_pos.push_back(32'(st));
        end
    endtask

    task automatic clear_capture();
        cap_data.delete(); cap_pos.delete(); cap_len.delete();
        cap_sel.delete(); cap_cyc.delete(); acc_cyc.delete();
        acc_cnt = 0; done_cnt = 0; seen_rdy = 0; timeout = 0;
    endtask

    // run one job to completion (bounded), words[] must be prepared
    task automatic run_job(input logic [1:0] sel, input int L, input int vm);
        int n;
        @(posedge clk); #3;
        clear_capture();
        vmode  = vm;
        drv_en = 1'b1;
        @(posedge clk); #3;
        start = 1'b1; sel_type_i = sel; length_i = 32'(L);
        @(posedge clk); #3;
        start = 1'b0; sel_type_i = 2'($urandom); length_i = $urandom;
        n = 0;
        while (done_cnt == 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt == 0) timeout = 1'b1;
        repeat (3) @(posedge clk);
        #3 drv_en = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if (data !== 128'd0)          begin bad++; $display("FAIL rst_data got=%h exp=0", data); end
        total++; if (data_position !== 32'd0)  begin bad++; $display("FAIL rst_pos got=%h exp=0", data_position); end
        total++; if (data_length !== 32'd0)    begin bad++; $display("FAIL rst_len got=%h exp=0", data_length); end
        total++; if (sel_type !== 2'd0)        begin bad++; $display("FAIL rst_sel got=%h exp=0", sel_type); end
        total++; if (bus.in_ready !== 1'b0)    begin bad++; $display("FAIL rst_ready got=%b exp=0", bus.in_ready); end
        total++; if (process_en !== 1'b0)      begin bad++; $display("FAIL rst_pe got=%b exp=0", process_en); end
        total++; if (busy !== 1'b0)            begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0)            begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
        @(posedge clk); #3 rst_n = 1'b1;
    endtask

    task automatic test_aead20();
        logic [127:0] d0, d1;
        logic [31:0]  p0, p1;
        words.delete();
        words.push_back(32'h00010203); words.push_back(32'h04050607);
        words.push_back(32'h08090A0B); words.push_back(32'h0C0D0E0F);
        words.push_back(32'h10111213);
        run_job(AEAD128, 20, 0);
        d0 = (cap_data.size() > 0) ? cap_data[0] : 'x;
        d1 = (cap_data.size() > 1) ? cap_data[1] : 'x;
        p0 = (cap_pos.size() > 0) ? cap_pos[0] : 'x;
        p1 = (cap_pos.size() > 1) ? cap_pos[1] : 'x;
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL aead20_timeout no done seen"); end
        total++; if (cap_data.size() !== 2) begin bad++; $display("FAIL aead20_blocks got=%0d exp=2", cap_data.size()); end
        total++; if (d0 !== 128'h000102030405060708090A0B0C0D0E0F) begin bad++; $display("FAIL aead20_data0 got=%h exp=000102030405060708090a0b0c0d0e0f", d0); end
        total++; if (p0 !== 32'd0)  begin bad++; $display("FAIL aead20_pos0 got=%0d exp=0", p0); end
        total++; if (d1 !== 128'h10111213) begin bad++; $display("FAIL aead20_data1 got=%h exp=10111213", d1); end
        total++; if (p1 !== 32'd16) begin bad++; $display("FAIL aead20_pos1 got=%0d exp=16", p1); end
        total++; if (acc_cnt !== 5) begin bad++; $display("FAIL aead20_words got=%0d exp=5", acc_cnt); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL aead20_done got=%0d exp=1", done_cnt); end
        total++; if (first_rdy_cyc - start_cyc !== 1) begin bad++; $display("FAIL aead20_ready_lat got=%0d exp=1", first_rdy_cyc - start_cyc); end
        total++;
        if (acc_cyc.size() != 5 || cap_cyc.size() != 2) begin
            bad++; $display("FAIL aead20_pe_lat got=acc%0d/pe%0d exp=5/2", acc_cyc.size(), cap_cyc.size());
        end else if (cap_cyc[0] - acc_cyc[3] !== 1 || cap_cyc[1] - acc_cyc[4] !== 1) begin
            bad++; $display("FAIL aead20_pe_lat got=%0d,%0d exp=1,1", cap_cyc[0] - acc_cyc[3], cap_cyc[1] - acc_cyc[4]);
        end
        total++; if (cap_len.size() > 0 && cap_len[0] !== 32'd20) begin bad++; $display("FAIL aead20_len got=%0d exp=20", cap_len[0]); end
    endtask

    task automatic test_hash8();
        logic [127:0] d0;
        words.delete();
        words.push_back(32'h00010203); words.push_back(32'h04050607);
        run_job(HASH256, 8, 0);
        d0 = (cap_data.size() > 0) ? cap_data[0] : 'x;
        total++; if (cap_data.size() !== 1) begin bad++; $display("FAIL hash8_blocks got=%0d exp=1", cap_data.size()); end
        total++; if (d0 !== 128'h0001020304050607) begin bad++; $display("FAIL hash8_data got=%h exp=0001020304050607", d0); end
        total++; if (cap_pos.size() > 0 && cap_pos[0] !== 32'd0) begin bad++; $display("FAIL hash8_pos got=%0d exp=0", cap_pos[0]); end
        total++; if (cap_sel.size() > 0 && cap_sel[0] !== HASH256) begin bad++; $display("FAIL hash8_sel got=%0d exp=1", cap_sel[0]); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL hash8_done got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_hash5_partial();
        logic [127:0] d0;
        words.delete();
        words.push_back(32'h00010203); words.push_back(32'h04AABBCC);
        run_job(HASH256, 5, 0);
        d0 = (cap_data.size() > 0) ? cap_data[0] : 'x;
        total++; if (cap_data.size() !== 1) begin bad++; $display("FAIL hash5_blocks got=%0d exp=1", cap_data.size()); end
        total++; if (d0 !== 128'h0001020304) begin bad++; $display("FAIL hash5_data got=%h exp=0001020304", d0); end
        total++; if (acc_cnt !== 2) begin bad++; $display("FAIL hash5_words got=%0d exp=2", acc_cnt); end
    endtask

    task automatic test_empty();
        words.delete();
        run_job(AEAD128, 0, 0);
        total++; if (seen_rdy !== 1'b0) begin bad++; $display("FAIL empty_ready got=%b exp=0", seen_rdy); end
        total++; if (cap_data.size() !== 1) begin bad++; $display("FAIL empty_blocks got=%0d exp=1", cap_data.size()); end
        total++; if (cap_data.size() > 0 && cap_data[0] !== 128'd0) begin bad++; $display("FAIL empty_data got=%h exp=0", cap_data[0]); end
        total++; if (cap_pos.size() > 0 && cap_pos[0] !== 32'd0) begin bad++; $display("FAIL empty_pos got=%0d exp=0", cap_pos[0]); end
        total++; if (done_cyc - start_cyc !== 3) begin bad++; $display("FAIL empty_latency got=%0d exp=3", done_cyc - start_cyc); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL empty_done got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_toggle32();
        prep_random(32);
        build_expect(AEAD128, 32);
        run_job(AEAD128, 32, 1);
        total++; if (cap_data.size() !== 2) begin bad++; $display("FAIL toggle_blocks got=%0d exp=2", cap_data.size()); end
        for (int b = 0; b < 2; b++) begin
            total++;
            if (cap_data.size() <= b || cap_data[b] !== exp_data[b] || cap_pos[b] !== exp_pos[b]) begin
                bad++;
                $display("FAIL toggle_block%0d got=%h@%0d exp=%h@%0d", b,
                         (cap_data.size() > b) ? cap_data[b] : 128'hx,
                         (cap_pos.size() > b) ? cap_pos[b] : 32'hx, exp_data[b], exp_pos[b]);
            end
        end
        total++; if (acc_cnt !== 8) begin bad++; $display("FAIL toggle_words got=%0d exp=8", acc_cnt); end
    endtask

    task automatic test_reset_mid();
        int n;
        logic [31:0] w;
        prep_random(20);
        @(posedge clk); #3;
        clear_capture();
        vmode = 2; drv_en = 1'b1;
        @(posedge clk); #3;
        start = 1'b1; sel_type_i = AEAD128; length_i = 32'd20;
        @(posedge clk); #3;
        start = 1'b0;
        n = 0;
        while (acc_cnt < 2 && n < 200) begin @(posedge clk); n++; end
        @(negedge clk); #2;
        rst_n = 1'b0; drv_en = 1'b0;
        #1;
        total++; if ({process_en, busy, done, bus.in_ready} !== 4'b0000) begin bad++; $display("FAIL midrst_ctrl got=%b exp=0000", {process_en, busy, done, bus.in_ready}); end
        total++; if ({data, data_position, data_length, sel_type} !== 194'd0) begin bad++; $display("FAIL midrst_outputs got=%h/%0d/%0d/%0d exp=0", data, data_position, data_length, sel_type); end
        repeat (3) @(posedge clk);
        total++; if (cap_data.size() !== 0 || done_cnt !== 0) begin bad++; $display("FAIL midrst_stale got=pe%0d/done%0d exp=0/0", cap_data.size(), done_cnt); end
        #3 rst_n = 1'b1;
        w = $urandom;
        words.delete();
        words.push_back(w);
        run_job(2'($urandom_range(0, 3)), 4, 0);
        total++; if (cap_data.size() !== 1) begin bad++; $display("FAIL midrst_new_blocks got=%0d exp=1", cap_data.size()); end
        total++; if (cap_data.size() > 0 && cap_data[0] !== {96'd0, w}) begin bad++; $display("FAIL midrst_new_data got=%h exp=%h", cap_data[0], w); end
    endtask

    task automatic test_random();
        logic [1:0] sel;
        int L, vm, nb;
        for (int t = 0; t < 12; t++) begin
            sel = 2'($urandom_range(0, 3));
            L   = $urandom_range(0, 40);
            vm  = $urandom_range(0, 2);
            prep_random(L);
            build_expect(sel, L);
            run_job(sel, L, vm);
            nb = exp_data.size();
            total++; if (timeout !== 1'b0 || done_cnt !== 1) begin bad++; $display("FAIL rnd%0d_done got=%0d exp=1 (L=%0d sel=%0d)", t, done_cnt, L, sel); end
            total++; if (cap_data.size() !== nb) begin bad++; $display("FAIL rnd%0d_blocks got=%0d exp=%0d (L=%0d sel=%0d)", t, cap_data.size(), nb, L, sel); end
            for (int b = 0; b < nb; b++) begin
                total++;
                if (cap_data.size() <= b || cap_data[b] !== exp_data[b] || cap_pos[b] !== exp_pos[b]
                    || cap_len[b] !== 32'(L) || cap_sel[b] !== sel) begin
                    bad++;
                    $display("FAIL rnd%0d_block%0d got=%h@%0d exp=%h@%0d (L=%0d sel=%0d)", t, b,
                             (cap_data.size() > b) ? cap_data[b] : 128'hx,
                             (cap_pos.size() > b) ? cap_pos[b] : 32'hx, exp_data[b], exp_pos[b], L, sel);
                end
                if (b > 0 && cap_cyc.size() > b) begin
                    total++;
                    if (cap_cyc[b] - cap_cyc[b-1] < 2) begin
                        bad++; $display("FAIL rnd%0d_gap got=%0d exp>=2", t, cap_cyc[b] - cap_cyc[b-1]);
                    end
                end
            end
            total++; if (acc_cnt !== (L + 3) / 4) begin bad++; $display("FAIL rnd%0d_words got=%0d exp=%0d", t, acc_cnt, (L + 3) / 4); end
        end
    endtask

    initial begin
        test_reset();
        test_aead20();
        test_hash8();
        test_hash5_partial();
        test_empty();
        test_toggle32();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
